param_updown_counter: RTL and testbench

- Parametrised successor of the 3-bit posedge up counter.
- Counts up or down modulo MODULUS and supports enable, synchronous parallel load and asynchronous preset.
- Provides a registered Gray-coded copy of the count, a terminal-count flag and a one-cycle wrap pulse.
- Used as the general counter/timebase for the lab designs and for cascading into wider counters.

---
 rtl/param_counter_pkg.sv | 24 ++
 rtl/counter_next_state.sv | 80 ++++++++
 rtl/param_updown_counter.sv | 106 ++++++++++
 tb/tb_param_updown_counter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// -----------------------------------------------------------------------------
// param_counter_pkg
//   Shared types and helpers for param_updown_counter and its next-state logic.
//   - GRAY_MAX_W  : widest count the Gray helper handles.
//   - count_dir_e : names for the UP input (DIR_DOWN = 0, DIR_UP = 1).
//   - gray_encode : binary to reflected Gray code. It works at GRAY_MAX_W bits;
//                   callers zero-extend their value in and truncate the result
//                   back to their own width, which is exact because Gray bit k
//                   depends only on binary bits k and k+1.
// -----------------------------------------------------------------------------
package param_counter_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  function automatic logic [GRAY_MAX_W-1:0] gray_encode(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/counter_next_state.sv
// -----------------------------------------------------------------------------
// counter_next_state
//   Combinational next-state logic of the modulo up/down counter. It holds no
//   state; the top module registers its outputs.
//
//   Build option: define PARAM_COUNTER_SATURATE_EN to make the counter stop at
//   the bounds instead of wrapping. In that build o_wrap_next is always 0.
//
//   Ports:
//     i_q          current count
//     i_en         count enable
//     i_up         direction (1 = up, 0 = down)
//     i_load       parallel load, takes priority over counting
//     i_d          load value, clamped to MODULUS-1
//     o_next_q     count to register at the next rising edge
//     o_wrap_next  1 when this edge wraps (MODULUS-1 -> 0 or 0 -> MODULUS-1)
// -----------------------------------------------------------------------------
module counter_next_state
  import param_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_wrap_next
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  count_dir_e       w_dir;
  logic [WIDTH-1:0] w_load_val;

  assign w_dir = count_dir_e'(i_up);

  // With a full binary range every D is already legal, so the clamp compare
  // is generated only when some D values lie outside the modulus.
  if (MODULUS < 2**WIDTH) begin : g_clamp
    assign w_load_val = (i_d > MAX_Q) ? MAX_Q : i_d;
  end else begin : g_no_clamp
    assign w_load_val = i_d;
  end

  always_comb begin
    o_next_q    = i_q;
    o_wrap_next = 1'b0;
    if (i_load) begin
      o_next_q = w_load_val;
    end else if (i_en) begin
      if (w_dir == DIR_UP) begin
        if (i_q == MAX_Q) begin
`ifdef PARAM_COUNTER_SATURATE_EN
          o_next_q    = i_q;
`else
          o_next_q    = '0;
          o_wrap_next = 1'b1;
`endif
        end else begin
          o_next_q = i_q + 1'b1;
        end
      end else begin
        if (i_q == '0) begin
`ifdef PARAM_COUNTER_SATURATE_EN
          o_next_q    = i_q;
`else
          o_next_q    = MAX_Q;
          o_wrap_next = 1'b1;
`endif
        end else begin
          o_next_q = i_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//   Modulo-MODULUS up/down counter with enable, synchronous load and
//   asynchronous reset/preset. This module is the register shell; the
//   next-count decision lives in counter_next_state.
//
//   Build option: PARAM_COUNTER_SATURATE_EN makes the counter saturate at
//   0 / MODULUS-1 instead of wrapping; WRAP then stays 0 and TC is unchanged.
//
//   Control priority: not_RST, not_PRE, LOAD, EN, hold.
//
//   Ports:
//     CLK      rising-edge clock
//     not_RST  async active-low reset   (Q = 0)
//     not_PRE  async active-low preset  (Q = PRESET_VALUE)
//     EN       count enable
//     UP       direction, 1 = up, 0 = down
//     LOAD     synchronous parallel load of D (clamped to MODULUS-1)
//     D        load value
//     Q        registered binary count
//     Q_GRAY   registered Gray code of Q, same flop stage as Q
//     TC       combinational terminal count, for the EN of a next stage
//     WRAP     registered one-cycle pulse following a wrap edge
// -----------------------------------------------------------------------------
module param_updown_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH        = 3,
  parameter int MODULUS      = 2**WIDTH,
  parameter int PRESET_VALUE = 2**WIDTH - 1
) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic             not_PRE,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_GRAY,
  output logic             TC,
  output logic             WRAP
);

  if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 1..30");
  end
  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (PRESET_VALUE < 0 || PRESET_VALUE >= MODULUS) begin : g_bad_preset
    $error("param_updown_counter: PRESET_VALUE must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_Q       = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PRESET_Q    = WIDTH'(PRESET_VALUE);
  localparam logic [WIDTH-1:0] PRESET_GRAY = WIDTH'(gray_encode(GRAY_MAX_W'(PRESET_VALUE)));

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_q;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_wrap_next;

  counter_next_state #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .i_q         (r_q),
    .i_en        (EN),
    .i_up        (UP),
    .i_load      (LOAD),
    .i_d         (D),
    .o_next_q    (w_next_q),
    .o_wrap_next (w_wrap_next)
  );

  // Gray is computed from the next count so it lands in the same edge as Q.
  assign w_next_gray = WIDTH'(gray_encode(GRAY_MAX_W'(w_next_q)));

  // Both async controls are in the sensitivity list; reset is tested first so
  // it wins when both are low.
  always_ff @(posedge CLK or negedge not_RST or negedge not_PRE) begin
    if (!not_RST) begin
      r_q      <= '0;
      r_q_gray <= '0;
      r_wrap   <= 1'b0;
    end else if (!not_PRE) begin
      r_q      <= PRESET_Q;
      r_q_gray <= PRESET_GRAY;
      r_wrap   <= 1'b0;
    end else begin
      r_q      <= w_next_q;
      r_q_gray <= w_next_gray;
      r_wrap   <= w_wrap_next;
    end
  end

  assign TC     = EN & ((UP & (r_q == MAX_Q)) | (~UP & (r_q == '0)));
  assign Q      = r_q;
  assign Q_GRAY = r_q_gray;
  assign WRAP   = r_wrap;

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//   Directed bench for param_updown_counter. Instance u_a uses the defaults
//   (WIDTH=3, MODULUS=8, PRESET_VALUE=7); instance u_b uses MODULUS=5.
//   Expected values are hand-computed tables.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_param_updown_counter;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_pre_n, a_en, a_up, a_load;
  logic [2:0] a_d, a_q, a_gray;
  logic       a_tc, a_wrap;

  logic       b_rst_n, b_pre_n, b_en, b_up, b_load;
  logic [2:0] b_d, b_q, b_gray;
  logic       b_tc, b_wrap;

  param_updown_counter #(.WIDTH(3)) u_a (
    .CLK(clk), .not_RST(a_rst_n), .not_PRE(a_pre_n), .EN(a_en), .UP(a_up),
    .LOAD(a_load), .D(a_d), .Q(a_q), .Q_GRAY(a_gray), .TC(a_tc), .WRAP(a_wrap)
  );

  param_updown_counter #(.WIDTH(3), .MODULUS(5), .PRESET_VALUE(4)) u_b (
    .CLK(clk), .not_RST(b_rst_n), .not_PRE(b_pre_n), .EN(b_en), .UP(b_up),
    .LOAD(b_load), .D(b_d), .Q(b_q), .Q_GRAY(b_gray), .TC(b_tc), .WRAP(b_wrap)
  );

  int n_vec = 0;
  int n_err = 0;

  // Gray code of 0..7, written out by hand.
  logic [2:0] g8 [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifndef PARAM_COUNTER_SATURATE_EN
  logic [2:0] exp_q1 [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
  logic [2:0] exp_q3 [6]  = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
  logic       exp_w3 [6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

  initial begin
    a_rst_n = 1'b0; a_pre_n = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_d = 3'd0;
    b_rst_n = 1'b0; b_pre_n = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_d = 3'd0;

    #3;
    chk("rst_a_q", 8'(a_q), 8'd0);
    chk("rst_a_gray", 8'(a_gray), 8'd0);
    chk("rst_a_wrap", 8'(a_wrap), 8'd0);
    chk("rst_b_q", 8'(b_q), 8'd0);
    #7;
    a_rst_n = 1'b1; a_en = 1'b1; a_up = 1'b1;

`ifndef PARAM_COUNTER_SATURATE_EN
    // Up count through the wrap; Gray must track Q in the same cycle.
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t1_q[%0d]", i), 8'(a_q), 8'(exp_q1[i]));
      chk($sformatf("t1_gray[%0d]", i), 8'(a_gray), 8'(g8[exp_q1[i]]));
      chk($sformatf("t1_tc[%0d]", i), 8'(a_tc), 8'(exp_q1[i] == 3'd7));
      chk($sformatf("t1_wrap[%0d]", i), 8'(a_wrap), 8'(i == 7));
    end

    // Async preset and reset between edges.
    step();
    chk("t2_q3", 8'(a_q), 8'd3);
    #2 a_pre_n = 1'b0;
    #1 chk("t2_pre_q", 8'(a_q), 8'd7);
    chk("t2_pre_gray", 8'(a_gray), 8'b100);
    chk("t2_pre_wrap", 8'(a_wrap), 8'd0);
    #1 a_rst_n = 1'b0;
    #1 chk("t2_both_q", 8'(a_q), 8'd0);
    chk("t2_both_gray", 8'(a_gray), 8'd0);
    #1 a_rst_n = 1'b1; a_pre_n = 1'b1;
    #1 chk("t2_release_q", 8'(a_q), 8'd0);
    step();
    chk("t2_resume_q1", 8'(a_q), 8'd1);
    step();
    chk("t2_resume_q2", 8'(a_q), 8'd2);

    // MODULUS=5 down count.
    chk("t3_rst_q", 8'(b_q), 8'd0);
    b_rst_n = 1'b1; b_en = 1'b1; b_up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t3_q[%0d]", i), 8'(b_q), 8'(exp_q3[i]));
      chk($sformatf("t3_gray[%0d]", i), 8'(b_gray), 8'(g8[exp_q3[i]]));
      chk($sformatf("t3_wrap[%0d]", i), 8'(b_wrap), 8'(exp_w3[i]));
      chk($sformatf("t3_tc[%0d]", i), 8'(b_tc), 8'(exp_q3[i] == 3'd0));
    end

    // Load clamp beats count, then wrap from the clamped value.
    b_load = 1'b1; b_d = 3'd6; b_en = 1'b1; b_up = 1'b1;
    step();
    chk("t4_clamp_q", 8'(b_q), 8'd4);
    chk("t4_clamp_wrap", 8'(b_wrap), 8'd0);
    chk("t4_clamp_tc", 8'(b_tc), 8'd1);
    b_load = 1'b0;
    step();
    chk("t4_wrap_q", 8'(b_q), 8'd0);
    chk("t4_wrap_wrap", 8'(b_wrap), 8'd1);
    chk("t4_wrap_tc", 8'(b_tc), 8'd0);
    b_load = 1'b1; b_d = 3'd2; b_en = 1'b0;
    step();
    chk("t4_load2_q", 8'(b_q), 8'd2);
    chk("t4_load2_wrap", 8'(b_wrap), 8'd0);
    b_load = 1'b0;
    step();
    chk("t4_hold_q", 8'(b_q), 8'd2);
    chk("t4_hold_tc", 8'(b_tc), 8'd0);
    b_en = 1'b1; b_up = 1'b0;
    step();
    chk("t4_down_q", 8'(b_q), 8'd1);
    b_up = 1'b1;
    step();
    chk("t4_dirchg_q", 8'(b_q), 8'd2);
    b_load = 1'b1; b_d = 3'd7; b_en = 1'b0;
    step();
    chk("t4_clamp7_q", 8'(b_q), 8'd4);
    chk("t4_clamp7_gray", 8'(b_gray), 8'b110);
`else
    // Saturating build: stop at 7 going up, at 0 going down, never wrap.
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t6_up_q[%0d]", i), 8'(a_q), (i < 6) ? 8'(i + 1) : 8'd7);
      chk($sformatf("t6_up_wrap[%0d]", i), 8'(a_wrap), 8'd0);
      chk($sformatf("t6_up_tc[%0d]", i), 8'(a_tc), (i < 6) ? 8'd0 : 8'd1);
    end
    a_up = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t6_dn_q[%0d]", i), 8'(a_q), (i < 7) ? 8'(6 - i) : 8'd0);
      chk($sformatf("t6_dn_wrap[%0d]", i), 8'(a_wrap), 8'd0);
    end
    chk("t6_dn_gray", 8'(a_gray), 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
